// File: rtl/operand_entry.sv
// Keypad front end for the calculator: builds two decimal operands and an operator,
// strobes the add/subtract stage and reads its result back so operations can be chained.
module operand_entry #(
    parameter int WIDTH     = 16,
    parameter int MAX_VALUE = 9999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_digit,
    input  logic             key_add,
    input  logic             key_sub,
    input  logic             key_equals,
    input  logic             key_clear,
    input  logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] first_input,
    output logic [WIDTH-1:0] second_input,
    output logic             add,
    output logic             subtract,
    output logic             begin_operation,
    output logic [WIDTH-1:0] display_value,
    output logic             key_reject,
    output logic [1:0]       state_out
);
    localparam logic [1:0] ENTER_A = 2'd0;
    localparam logic [1:0] ENTER_B = 2'd1;
    localparam logic [1:0] ISSUE   = 2'd2;
    localparam logic [1:0] SHOW    = 2'd3;

    localparam logic [WIDTH+3:0] MAX_EXT = (WIDTH+4)'(MAX_VALUE);

    logic [1:0]       state;
    logic             b_seen;
    logic             digit_ok;
    logic [WIDTH+3:0] dig_ext;
    logic [WIDTH+3:0] a_ext;
    logic [WIDTH+3:0] b_ext;
    logic [WIDTH+3:0] nxt_a;
    logic [WIDTH+3:0] nxt_b;
    logic             a_ok;
    logic             b_ok;

    // cur*10 + d kept 4 bits wide so the overflow test against MAX_VALUE cannot wrap
    always_comb begin
        digit_ok = (key_digit <= 4'd9);
        dig_ext  = {{WIDTH{1'b0}}, key_digit};
        a_ext    = {4'b0, first_input};
        b_ext    = {4'b0, second_input};
        nxt_a    = (a_ext << 3) + (a_ext << 1) + dig_ext;
        nxt_b    = (b_ext << 3) + (b_ext << 1) + dig_ext;
        a_ok     = digit_ok && (nxt_a <= MAX_EXT);
        b_ok     = digit_ok && (nxt_b <= MAX_EXT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ENTER_A;
            first_input     <= '0;
            second_input    <= '0;
            add             <= 1'b0;
            subtract        <= 1'b0;
            b_seen          <= 1'b0;
            begin_operation <= 1'b0;
            key_reject      <= 1'b0;
        end else begin
            begin_operation <= 1'b0;
            key_reject      <= 1'b0;
            if (key_clear) begin
                state        <= ENTER_A;
                first_input  <= '0;
                second_input <= '0;
                add          <= 1'b0;
                subtract     <= 1'b0;
                b_seen       <= 1'b0;
            end else begin
                case (state)
                    ENTER_A: begin
                        if (key_equals) begin
                            state <= ENTER_A;
                        end else if (key_add || key_sub) begin
                            add          <= key_add;
                            subtract     <= ~key_add;
                            second_input <= '0;
                            b_seen       <= 1'b0;
                            state        <= ENTER_B;
                        end else if (key_valid) begin
                            if (a_ok) first_input <= nxt_a[WIDTH-1:0];
                            else      key_reject  <= 1'b1;
                        end
                    end
                    ENTER_B: begin
                        if (key_equals) begin
                            begin_operation <= 1'b1;
                            state           <= ISSUE;
                        end else if (key_add || key_sub) begin
                            // operator may still be changed until B has a digit
                            if (!b_seen) begin
                                add      <= key_add;
                                subtract <= ~key_add;
                            end
                        end else if (key_valid) begin
                            if (b_ok) begin
                                second_input <= nxt_b[WIDTH-1:0];
                                b_seen       <= 1'b1;
                            end else begin
                                key_reject <= 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        state <= SHOW;
                    end
                    default: begin
                        if (key_equals) begin
                            first_input     <= result;
                            begin_operation <= 1'b1;
                            state           <= ISSUE;
                        end else if (key_add || key_sub) begin
                            first_input  <= result;
                            add          <= key_add;
                            subtract     <= ~key_add;
                            second_input <= '0;
                            b_seen       <= 1'b0;
                            state        <= ENTER_B;
                        end else if (key_valid) begin
                            if (digit_ok) begin
                                first_input  <= {{(WIDTH-4){1'b0}}, key_digit};
                                second_input <= '0;
                                add          <= 1'b0;
                                subtract     <= 1'b0;
                                state        <= ENTER_A;
                            end else begin
                                key_reject <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // display follows registered state only; result is already a register downstream
    always_comb begin
        display_value = first_input;
        case (state)
            ENTER_A: display_value = first_input;
            ENTER_B: display_value = b_seen ? second_input : first_input;
            default: display_value = result;
        endcase
    end

    assign state_out = state;
endmodule
